// File: rtl/credit_pkg.sv
// credit_pkg: shared widths, credit limit helper and sender FSM state encoding
package credit_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CREDIT_W = 4;
    function automatic int max_credits(input int w);
        return (1 << w) - 1;
    endfunction
    localparam int MAX_CREDITS = max_credits(DEF_CREDIT_W);
    typedef enum logic [1:0] {EMPTY, READY, STALL} state_t;
endpackage

// File: rtl/credit_sender_if.sv
// credit_sender_if: upstream payload handshake, downstream pulse and credit-return bundle
interface credit_sender_if import credit_pkg::*; #(parameter int DATA_W = DEF_DATA_W) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              credit_valid;
    logic [1:0]        credit_return;
    modport master (
        input  in_valid, in_data, credit_valid, credit_return,
        output in_ready, out_valid, out_data
    );
    modport slave (
        output in_valid, in_data, credit_valid, credit_return,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/credit_counter.sv
// credit_counter: saturating credit count with reload, look-ahead value and sticky overflow
module credit_counter import credit_pkg::*; #(
    parameter int CREDIT_W = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reinit,
    input  logic [CREDIT_W-1:0] initial_credits,
    input  logic                dec,
    input  logic                inc_valid,
    input  logic [1:0]          inc,
    output logic [CREDIT_W-1:0] credits,
    output logic [CREDIT_W-1:0] credits_next,
    output logic                overflow_err
);
    localparam logic [CREDIT_W+1:0] MAX = (CREDIT_W+2)'(max_credits(CREDIT_W));
    logic [CREDIT_W+1:0] sum;
    logic                sat;
    // two guard bits keep the raw sum exact so saturation is a plain compare
    always_comb begin
        sum = {2'b00, credits} - {{(CREDIT_W+1){1'b0}}, dec}
            + {{CREDIT_W{1'b0}}, inc_valid ? inc : 2'b00};
        sat = sum > MAX;
        credits_next = !rst_n ? '0 : reinit ? initial_credits : sat ? MAX[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
    end
    // count register and overflow flag; a reload discards the return so cannot overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits      <= '0;
            overflow_err <= 1'b0;
        end else begin
            credits      <= credits_next;
            overflow_err <= overflow_err | (!reinit && sat);
        end
    end
endmodule

// File: rtl/credit_sender.sv
// credit_sender: one-entry holding stage that forwards payloads only while credits remain
module credit_sender import credit_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CREDIT_W = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                reinit,
    input  logic [CREDIT_W-1:0] initial_credits,
    credit_sender_if.master     bus,
    output logic [CREDIT_W-1:0] credits,
    output logic [CREDIT_W-1:0] credits_next,
    output logic                overflow_err
);
    state_t            state, state_nx;
    logic              hold_valid, hold_nx, send, accept;
    logic [DATA_W-1:0] hold_data;

    credit_counter #(.CREDIT_W(CREDIT_W)) u_counter (
        .clk(clk),
        .rst_n(rst_n),
        .reinit(reinit),
        .initial_credits(initial_credits),
        .dec(send),
        .inc_valid(bus.credit_valid),
        .inc(bus.credit_return),
        .credits(credits),
        .credits_next(credits_next),
        .overflow_err(overflow_err)
    );

    // state register; READY/STALL mirror whether the registered count is non-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    // next state follows the holding register occupancy and the look-ahead credit count
    always_comb begin
        hold_nx  = accept || (hold_valid && !send);
        state_nx = !hold_nx ? EMPTY : (credits_next != '0) ? READY : STALL;
    end

    // send uses only registered credits, so same-cycle returns never enable it
    always_comb begin
        hold_valid   = state != EMPTY;
        send         = (state == READY) && !reinit;
        bus.in_ready = !hold_valid || send;
        accept       = bus.in_valid && bus.in_ready;
    end

    // holding payload and the registered one-cycle output pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            if (accept) hold_data <= bus.in_data;
            bus.out_valid <= send;
            if (send) bus.out_data <= hold_data;
        end
    end
endmodule

// File: tb/tb_credit_sender.sv
// tb_credit_sender: scenario tasks plus an out_data scoreboard for credit_sender
module tb_credit_sender;
    import credit_pkg::*;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reinit = 1'b0;
    logic [CW-1:0] initial_credits = '0;
    logic [CW-1:0] credits, credits_next;
    logic          overflow_err;
    int            compared = 0;
    int            mismatched = 0;
    logic [DW-1:0] q[$];

    credit_sender_if #(.DATA_W(DW)) bus();

    credit_sender #(.DATA_W(DW), .CREDIT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reinit(reinit),
        .initial_credits(initial_credits),
        .bus(bus.master),
        .credits(credits),
        .credits_next(credits_next),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // scoreboard: pop on every output pulse, push every beat that will be accepted
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n && bus.out_valid) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL out_data: unexpected pulse with data %h, none expected", bus.out_data);
            end else begin
                e = q.pop_front();
                if (bus.out_data !== e) begin
                    mismatched++;
                    $display("FAIL out_data: got %h want %h", bus.out_data, e);
                end
            end
        end
        if (rst_n && bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.credit_valid = 1'b1; bus.credit_return = 2'd3;
        reinit = 1'b1; initial_credits = 4'd7;
        step();
        compared++; if (credits !== 4'd0) begin mismatched++; $display("FAIL reset_credits: got %0d want 0", credits); end
        compared++; if (credits_next !== 4'd0) begin mismatched++; $display("FAIL reset_credits_next: got %0d want 0", credits_next); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        compared++; if (bus.out_data !== 8'h00) begin mismatched++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
        compared++; if (overflow_err !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow_err); end
        step();
        rst_n = 1'b1; bus.in_valid = 1'b0; bus.credit_valid = 1'b0; bus.credit_return = 2'd0; reinit = 1'b0;
    endtask

    task automatic test_stream;
        reinit = 1'b1; initial_credits = 4'd3;
        step();
        reinit = 1'b0;
        compared++; if (credits !== 4'd3) begin mismatched++; $display("FAIL stream_init: got %0d want 3", credits); end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'hA0 + 8'(i);
            #1;
            compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); end
            compared++; if (bus.out_valid !== (i >= 2)) begin mismatched++; $display("FAIL stream_pulse[%0d]: got %b want %b", i, bus.out_valid, i >= 2); end
            step();
        end
        bus.in_data = 8'hA4;
        #1;
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL stream_last_pulse: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd0) begin mismatched++; $display("FAIL stream_credits: got %0d want 0", credits); end
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL stream_stall_ready: got %b want 0", bus.in_ready); end
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL stream_stall_pulse: got %b want 0", bus.out_valid); end
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL stream_stall_hold: got %b want 0", bus.in_ready); end
    endtask

    task automatic test_return;
        bus.credit_valid = 1'b1; bus.credit_return = 2'd2;
        #1;
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL return_no_send: got %b want 0", bus.in_ready); end
        compared++; if (credits_next !== 4'd2) begin mismatched++; $display("FAIL return_next: got %0d want 2", credits_next); end
        step();
        bus.credit_valid = 1'b0; bus.credit_return = 2'd0;
        #1;
        compared++; if (credits !== 4'd2) begin mismatched++; $display("FAIL return_credits: got %0d want 2", credits); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL return_ready: got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL return_pulse_a3: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd1) begin mismatched++; $display("FAIL return_credits_1: got %0d want 1", credits); end
        step();
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL return_pulse_a4: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd0) begin mismatched++; $display("FAIL return_credits_0: got %0d want 0", credits); end
        step();
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL return_idle: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow;
        reinit = 1'b1; initial_credits = 4'd14;
        step();
        reinit = 1'b0; bus.credit_valid = 1'b1; bus.credit_return = 2'd1;
        #1;
        compared++; if (credits_next !== 4'd15) begin mismatched++; $display("FAIL ovf_edge_next: got %0d want 15", credits_next); end
        step();
        compared++; if (overflow_err !== 1'b0) begin mismatched++; $display("FAIL ovf_at_max: got %b want 0", overflow_err); end
        reinit = 1'b1; initial_credits = 4'd14; bus.credit_valid = 1'b0;
        step();
        reinit = 1'b0; bus.credit_valid = 1'b1; bus.credit_return = 2'd3;
        #1;
        compared++; if (credits_next !== 4'd15) begin mismatched++; $display("FAIL ovf_sat_next: got %0d want 15", credits_next); end
        step();
        bus.credit_valid = 1'b0; bus.credit_return = 2'd0;
        compared++; if (credits !== 4'd15) begin mismatched++; $display("FAIL ovf_credits: got %0d want 15", credits); end
        compared++; if (overflow_err !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b want 1", overflow_err); end
        reinit = 1'b1; initial_credits = 4'd2;
        step();
        reinit = 1'b0;
        compared++; if (credits !== 4'd2) begin mismatched++; $display("FAIL ovf_reinit_credits: got %0d want 2", credits); end
        compared++; if (overflow_err !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_same_cycle;
        reinit = 1'b1; initial_credits = 4'd1;
        step();
        reinit = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hB0;
        step();
        bus.in_data = 8'hB1; bus.credit_valid = 1'b1; bus.credit_return = 2'd1;
        #1;
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL same_ready: got %b want 1", bus.in_ready); end
        compared++; if (credits_next !== 4'd1) begin mismatched++; $display("FAIL same_next: got %0d want 1", credits_next); end
        step();
        bus.in_valid = 1'b0; bus.credit_valid = 1'b0; bus.credit_return = 2'd0;
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL same_pulse_b0: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd1) begin mismatched++; $display("FAIL same_credits: got %0d want 1", credits); end
        step();
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL same_pulse_b1: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd0) begin mismatched++; $display("FAIL same_credits_end: got %0d want 0", credits); end
        step();
    endtask

    task automatic test_reinit;
        reinit = 1'b1; initial_credits = 4'd5;
        step();
        reinit = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hC0;
        step();
        bus.in_valid = 1'b0; reinit = 1'b1; initial_credits = 4'd4; bus.credit_valid = 1'b1; bus.credit_return = 2'd3;
        #1;
        compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL reinit_ready: got %b want 0", bus.in_ready); end
        compared++; if (credits_next !== 4'd4) begin mismatched++; $display("FAIL reinit_next: got %0d want 4", credits_next); end
        step();
        reinit = 1'b0; bus.credit_valid = 1'b0; bus.credit_return = 2'd0;
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reinit_no_pulse: got %b want 0", bus.out_valid); end
        compared++; if (credits !== 4'd4) begin mismatched++; $display("FAIL reinit_credits: got %0d want 4", credits); end
        step();
        compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL reinit_late_pulse: got %b want 1", bus.out_valid); end
        compared++; if (credits !== 4'd3) begin mismatched++; $display("FAIL reinit_after_send: got %0d want 3", credits); end
        step();
    endtask

    task automatic test_reset_mid;
        reinit = 1'b1; initial_credits = 4'd3;
        step();
        reinit = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hD0;
        step();
        bus.in_valid = 1'b0; rst_n = 1'b0;
        #1;
        q.delete();
        compared++; if (credits !== 4'd0) begin mismatched++; $display("FAIL mid_credits: got %0d want 0", credits); end
        compared++; if (credits_next !== 4'd0) begin mismatched++; $display("FAIL mid_next: got %0d want 0", credits_next); end
        compared++; if (overflow_err !== 1'b0) begin mismatched++; $display("FAIL mid_overflow: got %b want 0", overflow_err); end
        compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ready: got %b want 1", bus.in_ready); end
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_pulse: got %b want 0", bus.out_valid); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_after[%0d]: got %b want 0", i, bus.out_valid); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.credit_valid = 1'b0; bus.credit_return = 2'd0;
        test_reset();
        test_stream();
        test_return();
        test_overflow();
        test_same_cycle();
        test_reinit();
        test_reset_mid();
        compared++; if (q.size() != 0) begin mismatched++; $display("FAIL drain: %0d payloads never sent, want 0", q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter CREDIT_W, default 4, credit counter width; maximum credits 2^CREDIT_W-1.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 reinit  in  1  synchronous reload of the credit count from initial_credits.
REQ-007 initial_credits  in  CREDIT_W  credit value loaded on reinit.
REQ-008 in_valid  in  1  upstream payload valid.
REQ-009 in_ready  out  1  upstream payload accepted when in_valid&&in_ready.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 out_valid  out  1  one-cycle pulse per payload sent downstream; no downstream backpressure.
REQ-012 out_data  out  DATA_W  payload qualified by out_valid.
REQ-013 credit_valid  in  1  qualifies credit_return.
REQ-014 credit_return  in  2  credits returned this cycle, 0..3.
REQ-015 credits  out  CREDIT_W  registered credit count.
REQ-016 credits_next  out  CREDIT_W  combinational value credits takes at the next edge.
REQ-017 overflow_err  out  1  sticky; set when a credit return saturates the count.

Function
REQ-018 One-entry holding register (hold_valid, hold_data) between in_* and out_*.
REQ-019 send = hold_valid && (credits != 0) && !reinit; evaluated on registered credits only; credits returned in the same cycle do not enable a send.
REQ-020 in_ready = !hold_valid || send; back-to-back acceptance at full rate while credits last.
REQ-021 Accept at edge N loads hold_data; send earliest in cycle N+1; out_valid/out_data registered, high in cycle N+2 for exactly one cycle.
REQ-022 FSM states: EMPTY (!hold_valid), READY (hold_valid, credits!=0), STALL (hold_valid, credits==0). EMPTY->READY/STALL on accept. READY->EMPTY on send without new accept. READY->READY on send with accept. STALL->READY when credits become non-zero.
REQ-023 credits_next = initial_credits when reinit; otherwise credits - send + (credit_valid ? credit_return : 0), computed at CREDIT_W+2 bits.
REQ-024 Sum above the maximum saturates at 2^CREDIT_W-1 and sets overflow_err; the excess is discarded.
REQ-025 Underflow is impossible by REQ-019; no wrap-around below 0.
REQ-026 reinit suppresses send for that cycle, discards that cycle's credit_return, and retains holding-register contents; upstream acceptance continues per REQ-020.
REQ-027 Simultaneous send and return of k credits: net change -1+k in one cycle.
REQ-028 overflow_err clears only on rst_n; reinit does not clear it.

Reset
REQ-029 On rst_n low, asynchronously: credits=0, hold_valid=0, out_valid=0, out_data=0, overflow_err=0, FSM=EMPTY.
REQ-030 While in reset, in_ready=1 and credits_next=0; the first accept occurs at the first rising edge after rst_n deasserts.
REQ-031 Reset asserted mid-transfer discards the held payload; no out_valid pulse follows.

Structure
REQ-032 Package credit_pkg holds CREDIT_W default, MAX_CREDITS constant, and the FSM state enum.
REQ-033 Sub-module credit_counter implements the saturating up/down count with reinit, credits_next and overflow flag; credit_sender instantiates it once.

Verification
REQ-034 rst_n low then high, reinit with initial_credits=3, stream 5 payloads 0xA0..0xA4 -> out_valid for A0,A1,A2 on consecutive cycles; credits reach 0; FSM in STALL; in_ready=0.
REQ-035 From REQ-034 state, credit_valid=1, credit_return=2 -> credits=2 next cycle, then A3,A4 sent in order; credits end at 0.
REQ-036 credits=14, credit_return=3 with no send -> credits=15, overflow_err=1 and remains set after reinit.
REQ-037 credits=1, hold_valid=1, same-cycle credit_return=1 -> send occurs, credits stays 1; next payload sent the following cycle.
REQ-038 reinit in a cycle with hold_valid and credits=5 -> no out_valid two cycles later, credits=initial_credits, held payload sent afterward.
REQ-039 rst_n asserted while hold_valid=1 -> all outputs at reset values immediately; no out_valid after release.
